gb_stream_aligner: RTL and testbench
====================================

Name: gb_stream_aligner

Overview:
- Reader-side counterpart to the fixed shift-register delay in the gray-balance pipeline.
- Stores side-band pixel data (e.g. original pixel or sync bits) when it enters a variable-latency compute path.
- Pops that data when the compute result returns, so data and result leave together aligned.
- Replaces fixed DELAY_CYCLE compensation wherever pipe latency is not constant.

Parameters:
- DATA_WIDTH, 16, width of side-band data stored at pipe entry
- RES_WIDTH, 16, width of compute result
- DEPTH, 8, FIFO entries; must be a power of 2, >= 2
- ADDR_WIDTH, 3, log2(DEPTH)

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  synchronous flush (frame start)
- in_valid  in  1  side-band push request
- in_data  in  DATA_WIDTH  side-band data
- in_ready  out  1  high when a push is accepted (not full)
- res_valid  in  1  compute result strobe; no backpressure
- res_data  in  RES_WIDTH  compute result
- out_valid  out  1  aligned output strobe
- out_data  out  DATA_WIDTH  popped side-band data
- out_res  out  RES_WIDTH  registered result
- err_over  out  1  sticky overflow flag
- err_under  out  1  sticky underflow flag

Behaviour:
- Reset: clk and rst_n as already decided (rst_n asynchronous, active-low; clock clk).
  - Pointers and count = 0.
  - out_valid, out_data, out_res, err_over, err_under = 0.
  - in_ready = 1.
- Storage: circular RAM of DEPTH x DATA_WIDTH.
  - wr_ptr and rd_ptr are ADDR_WIDTH wide and wrap naturally from DEPTH-1 to 0.
  - count is ADDR_WIDTH+1 wide.
- in_ready = (count != DEPTH), combinational from count.
- Push: occurs when in_valid && in_ready; writes in_data at wr_ptr, wr_ptr+1.
- Pop: occurs when res_valid && count != 0, evaluated on pre-cycle count.
  - rd_ptr+1.
  - Next cycle: out_valid = 1, out_data = head entry, out_res = res_data.
- Latency: exactly 1 cycle from res_valid to out_valid; out_* are registered.
  - out_data/out_res hold their last value when out_valid = 0.
- No write-through: with count == 0, res_valid is an underflow even if a push occurs in the same cycle.
  - On underflow: err_under set, no out_valid, the push still completes.
- Overflow: in_valid && !in_ready (count == DEPTH, no room) sets err_over and drops the push.
  - A push and pop together at full is legal: count unchanged, no error.
- Count update:
  - +1 on push only
  - -1 on pop only
  - unchanged on both or neither
- clr has priority over push and pop in the same cycle.
  - Pointers and count = 0, err flags = 0, out_valid = 0 next cycle.
  - RAM contents are not cleared.
- Error flags are sticky until clr or reset.
- Reset mid-stream discards all entries; no output follows the reset.

Optional Feature:
- Macro GB_STREAM_ALIGNER_LEVEL_EN.
- Defined: adds output port level [ADDR_WIDTH:0] = current count, registered, reset 0.
  - Also adds output max_level [ADDR_WIDTH:0], the high-water mark since the last clr/reset.
- Undefined: neither port exists and no related logic is generated.

Decomposition:
- Shared package gb_pkg:
  - DATA_WIDTH/RES_WIDTH defaults
  - the clog2 helper function used to derive ADDR_WIDTH
- One natural sub-module: gb_sync_fifo, which holds RAM, pointers, count and the full/empty flags.
- gb_stream_aligner keeps the error flags, output registers and optional level logic.

Test Plan:
- Fixed-latency check: push 0x0011, 0x0022, 0x0033; results 0xA1, 0xA2, 0xA3 arrive 4 cycles after each push -> out pairs (0x0011,0xA1), (0x0022,0xA2), (0x0033,0xA3), each 1 cycle after res_valid; err flags 0.
- Fill and overflow: 8 pushes 0x0001..0x0008 with no results -> in_ready = 0.
  - 9th push 0x0009 -> err_over = 1.
  - 8 results -> outputs 0x0001..0x0008 only.
- Full simultaneous: at count = 8, push 0x0100 with res_valid=1, res_data=0xFF -> out (0x0001,0xFF), count stays 8, err_over = 0.
- Empty underflow: count = 0, in_valid=1 data 0x0055 and res_valid=1 in the same cycle -> err_under = 1, no out_valid, count = 1.
  - Next res_valid 0x77 -> out (0x0055,0x77).
- Pointer wrap: 20 push/pop pairs with latency 3 and data = index -> outputs 0..19 in order, wr_ptr/rd_ptr wrap twice.
- clr/reset: with 5 entries and err_over=1, assert clr together with a push -> count 0, err flags 0, push ignored.
  - Repeat with rst_n low mid-stream -> all outputs 0, no out_valid after release.

Source files
------------

// File: rtl/gb_pkg.sv
// Shared defaults and helpers for the gray-balance stream aligner.
// Optional level monitor in gb_stream_aligner: GB_STREAM_ALIGNER_LEVEL_EN.
package gb_pkg;

    localparam int GB_DATA_WIDTH = 16;
    localparam int GB_RES_WIDTH  = 16;
    localparam int GB_DEPTH      = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/gb_sync_fifo.sv
// Circular side-band store: RAM, wrapping pointers, count and full/empty.
// Callers pass already-qualified push/pop strobes; clr wins over both.
module gb_sync_fifo
    import gb_pkg::*;
#(
    parameter int DW    = GB_DATA_WIDTH,
    parameter int DEPTH = GB_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] wr_data,
    output logic [DW-1:0] rd_data,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);
    localparam logic [AW-1:0] STEP   = AW'(1);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    assign rd_data = mem_q[rd_ptr_q];
    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + STEP;
            if (pop)  rd_ptr_d = rd_ptr_q + STEP;
            unique case ({push, pop})
                2'b10:   count_d = count_q + ONE;
                2'b01:   count_d = count_q - ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // Head is read combinationally before a same-cycle overwrite at full.
    always_ff @(posedge clk) begin
        if (push && !clr) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/gb_stream_aligner.sv
// Pairs side-band data stored at pipe entry with late compute results.
// Define GB_STREAM_ALIGNER_LEVEL_EN to add level/max_level outputs.
module gb_stream_aligner
    import gb_pkg::*;
#(
    parameter int DATA_WIDTH = GB_DATA_WIDTH,
    parameter int RES_WIDTH  = GB_RES_WIDTH,
    parameter int DEPTH      = GB_DEPTH,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  in_ready,
    input  logic                  res_valid,
    input  logic [RES_WIDTH-1:0]  res_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [RES_WIDTH-1:0]  out_res,
    output logic                  err_over,
    output logic                  err_under
`ifdef GB_STREAM_ALIGNER_LEVEL_EN
    ,
    output logic [ADDR_WIDTH:0]   level,
    output logic [ADDR_WIDTH:0]   max_level
`endif
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic                  full, empty;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] head;
    logic [ADDR_WIDTH:0]   count;

    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [RES_WIDTH-1:0]  out_res_q;
    logic                  err_over_q, err_under_q;

    // A pop frees the head slot, so a push at full is still accepted.
    assign pop      = res_valid && !empty;
    assign push     = in_valid && (!full || pop);
    assign in_ready = (count != FULL_CNT);

    gb_sync_fifo #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (ADDR_WIDTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .push    (push),
        .pop     (pop),
        .wr_data (in_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_res_q   <= '0;
            err_over_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else if (clr) begin
            out_valid_q <= 1'b0;
            err_over_q  <= 1'b0;
            err_under_q <= 1'b0;
        end else begin
            out_valid_q <= pop;
            if (pop) begin
                out_data_q <= head;
                out_res_q  <= res_data;
            end
            if (in_valid && full && !pop) err_over_q  <= 1'b1;
            if (res_valid && empty)       err_under_q <= 1'b1;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_res   = out_res_q;
    assign err_over  = err_over_q;
    assign err_under = err_under_q;

`ifdef GB_STREAM_ALIGNER_LEVEL_EN
    localparam logic [ADDR_WIDTH:0] ONE = (ADDR_WIDTH+1)'(1);

    logic [ADDR_WIDTH:0] level_d, level_q, max_q;

    always_comb begin
        level_d = count;
        unique case ({push, pop})
            2'b10:   level_d = count + ONE;
            2'b01:   level_d = count - ONE;
            default: level_d = count;
        endcase
        if (clr) level_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= '0;
            max_q   <= '0;
        end else begin
            level_q <= level_d;
            if (clr)                  max_q <= '0;
            else if (level_d > max_q) max_q <= level_d;
        end
    end

    assign level     = level_q;
    assign max_level = max_q;
`endif

endmodule

// File: tb/tb_gb_stream_aligner.sv
// Self-checking bench for gb_stream_aligner: directed plan plus random traffic
// against a queue-based reference model.
module tb_gb_stream_aligner;

    localparam int DW = 16;
    localparam int RW = 16;
    localparam int DEPTH = 8;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_ready;
    logic          res_valid = 1'b0;
    logic [RW-1:0] res_data = '0;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [RW-1:0] out_res;
    logic          err_over;
    logic          err_under;
`ifdef GB_STREAM_ALIGNER_LEVEL_EN
    logic [AW:0]   level;
    logic [AW:0]   max_level;
`endif

    gb_stream_aligner dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_res   (out_res),
        .err_over  (err_over),
`ifdef GB_STREAM_ALIGNER_LEVEL_EN
        .err_under (err_under),
        .level     (level),
        .max_level (max_level)
`else
        .err_under (err_under)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    // Reference model state
    logic [DW-1:0] q[$];
    logic          m_valid = 1'b0;
    logic [DW-1:0] m_data = '0;
    logic [RW-1:0] m_res = '0;
    logic          m_over = 1'b0;
    logic          m_under = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
        chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
        chk({tag, ".out_res"}, 32'(out_res), 32'(m_res));
        chk({tag, ".err_over"}, 32'(err_over), 32'(m_over));
        chk({tag, ".err_under"}, 32'(err_under), 32'(m_under));
`ifdef GB_STREAM_ALIGNER_LEVEL_EN
        chk({tag, ".level"}, 32'(level), 32'(q.size()));
`endif
    endtask

    // One clock: drive, check in_ready, update model, check registered outputs.
    task automatic cyc(input string tag, input logic c, input logic iv,
                       input logic [DW-1:0] id, input logic rv,
                       input logic [RW-1:0] rd);
        bit popped;
        bit was_full;
        clr = c;
        in_valid = iv;
        in_data = id;
        res_valid = rv;
        res_data = rd;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(q.size() != DEPTH));
        if (c) begin
            q.delete();
            m_valid = 1'b0;
            m_over = 1'b0;
            m_under = 1'b0;
        end else begin
            was_full = (q.size() == DEPTH);
            popped = rv && (q.size() != 0);
            if (rv && q.size() == 0) m_under = 1'b1;
            if (iv && was_full && !popped) m_over = 1'b1;
            if (popped) begin
                m_data = q.pop_front();
                m_res = rd;
            end
            if (iv && (!was_full || popped)) q.push_back(id);
            m_valid = popped;
        end
        @(posedge clk);
        #1;
        chk_outs(tag);
    endtask

    task automatic idle(input string tag, input int n);
        for (int i = 0; i < n; i++) cyc(tag, 1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic model_reset();
        q.delete();
        m_valid = 1'b0;
        m_data = '0;
        m_res = '0;
        m_over = 1'b0;
        m_under = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] fx_d [3];
        logic [RW-1:0] fx_r [3];
        fx_d = '{16'h0011, 16'h0022, 16'h0033};
        fx_r = '{16'h00A1, 16'h00A2, 16'h00A3};

        // Reset state
        #12;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        chk_outs("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fixed latency 4: pushes at t=0..2, results at t=4..6
        for (int t = 0; t < 8; t++) begin
            cyc("fixed", 1'b0, t < 3, (t < 3) ? fx_d[t % 3] : 16'h0,
                (t >= 4 && t < 7), (t >= 4 && t < 7) ? fx_r[(t + 2) % 3] : 16'h0);
        end

        // Fill, overflow, then push+pop at full
        for (int i = 1; i <= 8; i++) cyc("fill", 1'b0, 1'b1, DW'(i), 1'b0, '0);
        cyc("over", 1'b0, 1'b1, 16'h0009, 1'b0, '0);
        cyc("fullsim", 1'b0, 1'b1, 16'h0100, 1'b1, 16'h00FF);
        for (int i = 0; i < 8; i++) cyc("drain", 1'b0, 1'b0, '0, 1'b1, RW'(16'hB0 + i));
        idle("idle1", 2);

        // Underflow with same-cycle push
        cyc("clr0", 1'b1, 1'b0, '0, 1'b0, '0);
        cyc("under", 1'b0, 1'b1, 16'h0055, 1'b1, 16'h0066);
        cyc("under2", 1'b0, 1'b0, '0, 1'b1, 16'h0077);
        idle("idle2", 1);

        // Pointer wrap: 20 items, latency 3
        for (int t = 0; t < 23; t++) begin
            cyc("wrap", 1'b0, t < 20, DW'(t), t >= 3, RW'(16'hC00 + t));
        end

        // clr with push at 5 entries and err_over set
        for (int i = 0; i < 9; i++) cyc("cfill", 1'b0, 1'b1, DW'(16'h200 + i), 1'b0, '0);
        for (int i = 0; i < 3; i++) cyc("cpop", 1'b0, 1'b0, '0, 1'b1, RW'(i));
        cyc("clr", 1'b1, 1'b1, 16'h0BAD, 1'b0, '0);
        cyc("postclr", 1'b0, 1'b0, '0, 1'b1, 16'h0EEE);

        // Reset mid-stream
        for (int i = 0; i < 5; i++) cyc("rfill", 1'b0, 1'b1, DW'(16'h300 + i), 1'b0, '0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        res_valid = 1'b0;
        #2;
        model_reset();
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        chk_outs("rst");
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cyc("postrst", 1'b0, 1'b0, '0, 1'b1, 16'h0123);
        cyc("postrst2", 1'b0, 1'b1, 16'h0777, 1'b0, '0);
        cyc("postrst3", 1'b0, 1'b0, '0, 1'b1, 16'h0456);

        // Random traffic with varying push/pop bias
        for (int t = 0; t < 600; t++) begin
            int bias;
            bias = (t / 150) % 4;
            cyc("rand", ($urandom % 97) == 0,
                ($urandom % 4) < (bias + 1),
                DW'($urandom),
                ($urandom % 4) < (4 - bias),
                RW'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
